key_press_ctrl: RTL
===================

Name: key_press_ctrl

Overview:
- Front end that produces the `enter` and `override` strobes consumed by the screen state machine.
- Input: one raw active-low DE-board pushbutton.
- Processing: synchronise, debounce, then classify each press by hold time.
  - Short press gives a one-cycle `enter` pulse on debounced release.
  - A press held past the long-press threshold gives a one-cycle `override` pulse, and no `enter` for that press.

Parameters:
- CLK_FREQ_HZ, 50_000_000, system clock frequency.
- DEBOUNCE_CYCLES, CLK_FREQ_HZ/100, stable cycles (10 ms) required to accept a press or a release; must be ≥2.
- LONG_PRESS_CYCLES, CLK_FREQ_HZ*2, debounced-hold cycles (2 s) after which override fires; must be > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- key_n  input  1  raw pushbutton, asynchronous, 0 = pressed
- enter  output  1  one-cycle strobe, short press completed
- override  output  1  one-cycle strobe, long-press threshold reached
- pressed  output  1  debounced level: 1 in HELD and LONG_HELD
- key_state  output  3  current key_state_t, for debug and LEDs

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port `reset`; all flops are clocked on rising clk.
- Synchroniser: key_n passes through two flops and is inverted to give pressed_s (1 = pressed).
  - Reset loads both flops to 1 (released).
  - Latency from key_n to pressed_s is 2 cycles.
- Counters:
  - db_cnt is $clog2(DEBOUNCE_CYCLES) bits.
  - hold_cnt is $clog2(LONG_PRESS_CYCLES) bits; it never wraps because it saturates at the threshold.
- State machine (key_state_t), reset value IDLE:
  - IDLE: db_cnt=0. If pressed_s=1, go to PRESS_DB.
  - PRESS_DB: if pressed_s=0 (bounce), go to IDLE. Otherwise db_cnt++. When db_cnt==DEBOUNCE_CYCLES-1 with pressed_s=1, go to HELD with hold_cnt=0 and db_cnt=0.
  - HELD: hold_cnt++ each cycle.
    - If pressed_s=0, go to RELEASE_DB with long_flag=0 and db_cnt=0.
    - Else if hold_cnt==LONG_PRESS_CYCLES-1, go to LONG_HELD and assert override for 1 cycle.
    - If release and threshold coincide, release wins: no override, and enter is issued later.
  - LONG_HELD: hold_cnt frozen. If pressed_s=0, go to RELEASE_DB with long_flag=1 and db_cnt=0.
  - RELEASE_DB:
    - If pressed_s=1 (bounce), db_cnt=0 and stay in RELEASE_DB; hold_cnt does not advance.
    - Else db_cnt++. When db_cnt==DEBOUNCE_CYCLES-1 with pressed_s=0, go to IDLE and assert enter for 1 cycle, only if long_flag=0.
- Outputs:
  - enter and override are registered, asserted in the cycle immediately after the transitioning edge, and always exactly 1 cycle wide.
  - The two strobes are never high together.
  - At most one strobe is issued per physical press.
- Reset values: enter=0, override=0, pressed=0, key_state=IDLE, long_flag=0, all counters 0.
- Reset mid-press: the FSM returns to IDLE and no strobe is emitted.
  - A key still held after reset goes through PRESS_DB again, so it is treated as a new press.
- No auto-repeat: holding the key in LONG_HELD indefinitely produces no further pulses.

Decomposition:
- Add key_state_t to common_enums as a 3-bit logic enum: IDLE, PRESS_DB, HELD, LONG_HELD, RELEASE_DB.
- Sub-module sync_2ff: a parameterised reset-value two-flop synchroniser, reusable for the other KEY and SW inputs.
- Counters and the FSM remain in key_press_ctrl.

Test Plan:
All tests use DEBOUNCE_CYCLES=4 and LONG_PRESS_CYCLES=20.
- Clean short press: key_n low for 12 cycles, then high → exactly one enter pulse, 1 cycle wide, no override, pressed high while in HELD; enter appears 2+4 cycles (±1 for the state edge) after key_n rises.
- Bounce rejection: key_n toggles every 2 cycles for 20 cycles, then stays high → no enter, no override, key_state never reaches HELD.
- Long press: key_n low for 40 cycles, then released cleanly → override pulses once about 2+4+20 cycles after key_n falls; no enter after release; key_state sequence IDLE→PRESS_DB→HELD→LONG_HELD→RELEASE_DB→IDLE.
- Release bounce: after a 10-cycle clean press, key_n goes high/low/high with 1-cycle glitches → RELEASE_DB restarts; exactly one enter, issued 4 stable cycles after the last glitch.
- Reset mid-hold: hold key_n low and assert reset for 1 cycle at hold_cnt=10 → all outputs 0 and IDLE next cycle; a clean release afterwards gives no enter until a fresh debounced press completes.
- Threshold coincidence: arrange pressed_s to fall on the same cycle hold_cnt==19 → no override, one enter after release debounce.

Source files
------------

// File: rtl/key_press_ctrl_pkg.sv
// Shared types and helpers for the pushbutton front end.
package key_press_ctrl_pkg;

  // Debounce / hold-classification states of one pushbutton.
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PRESS_DB   = 3'd1,
    HELD       = 3'd2,
    LONG_HELD  = 3'd3,
    RELEASE_DB = 3'd4
  } key_state_t;

  // Convenience decode of the debounced "key is down" level.
  function automatic logic key_is_down(input key_state_t s);
    return (s == HELD) || (s == LONG_HELD);
  endfunction

endpackage

// File: rtl/key_press_ctrl_sync_2ff.sv
// Two-flop synchroniser with a parameterised reset value, for KEY/SW inputs.
module key_press_ctrl_sync_2ff #(
  parameter int          WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Two back-to-back flops resolve metastability of the asynchronous input.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/key_press_ctrl.sv
// Pushbutton front end: synchronise, debounce and classify each press as a
// short press (enter on release) or a long press (override at threshold).
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | key released and stable
// PRESS_DB   | press seen, waiting for DEBOUNCE_CYCLES stable samples
// HELD       | debounced press, hold time counting toward long press
// LONG_HELD  | long-press threshold reached, override already issued
// RELEASE_DB | release seen, waiting for DEBOUNCE_CYCLES stable samples
module key_press_ctrl
  import key_press_ctrl_pkg::*;
#(
  parameter int CLK_FREQ_HZ       = 50_000_000,
  parameter int DEBOUNCE_CYCLES   = CLK_FREQ_HZ / 100,
  parameter int LONG_PRESS_CYCLES = CLK_FREQ_HZ * 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_n,
  output logic       enter,
  output logic       override,
  output logic       pressed,
  output logic [2:0] key_state
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

  logic              w_key_n_sync;
  logic              w_pressed_s;

  key_state_t        r_state,     w_state_nxt;
  logic [DB_W-1:0]   r_db_cnt,    w_db_nxt;
  logic [HOLD_W-1:0] r_hold_cnt,  w_hold_nxt;
  logic              r_long_flag, w_long_nxt;
  logic              r_enter,     w_enter_nxt;
  logic              r_override,  w_override_nxt;

  // Released (1) is the safe reset value of the raw active-low key.
  key_press_ctrl_sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_sync_key (
    .i_clk   (clk),
    .i_reset (reset),
    .i_d     (key_n),
    .o_q     (w_key_n_sync)
  );

  assign w_pressed_s = ~w_key_n_sync;

  // State, counters and registered strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_db_cnt    <= '0;
      r_hold_cnt  <= '0;
      r_long_flag <= 1'b0;
      r_enter     <= 1'b0;
      r_override  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_db_cnt    <= w_db_nxt;
      r_hold_cnt  <= w_hold_nxt;
      r_long_flag <= w_long_nxt;
      r_enter     <= w_enter_nxt;
      r_override  <= w_override_nxt;
    end
  end

  // Next-state, counter updates and strobe requests.
  always_comb begin
    w_state_nxt    = r_state;
    w_db_nxt       = r_db_cnt;
    w_hold_nxt     = r_hold_cnt;
    w_long_nxt     = r_long_flag;
    w_enter_nxt    = 1'b0;
    w_override_nxt = 1'b0;

    case (r_state)
      IDLE: begin
        w_db_nxt = '0;
        if (w_pressed_s) w_state_nxt = PRESS_DB;
      end
      PRESS_DB: begin
        if (!w_pressed_s) begin
          w_state_nxt = IDLE;
          w_db_nxt    = '0;
        end else if (r_db_cnt == DB_LAST) begin
          w_state_nxt = HELD;
          w_hold_nxt  = '0;
          w_db_nxt    = '0;
        end else begin
          w_db_nxt = r_db_cnt + DB_W'(1);
        end
      end
      HELD: begin
        // Release is tested first so it wins over a coincident threshold.
        if (!w_pressed_s) begin
          w_state_nxt = RELEASE_DB;
          w_long_nxt  = 1'b0;
          w_db_nxt    = '0;
        end else if (r_hold_cnt == HOLD_LAST) begin
          w_state_nxt    = LONG_HELD;
          w_override_nxt = 1'b1;
        end else begin
          w_hold_nxt = r_hold_cnt + HOLD_W'(1);
        end
      end
      LONG_HELD: begin
        if (!w_pressed_s) begin
          w_state_nxt = RELEASE_DB;
          w_long_nxt  = 1'b1;
          w_db_nxt    = '0;
        end
      end
      RELEASE_DB: begin
        if (w_pressed_s) begin
          w_db_nxt = '0;
        end else if (r_db_cnt == DB_LAST) begin
          w_state_nxt = IDLE;
          w_db_nxt    = '0;
          w_enter_nxt = ~r_long_flag;
        end else begin
          w_db_nxt = r_db_cnt + DB_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_db_nxt    = '0;
      end
    endcase
  end

  assign enter     = r_enter;
  assign override  = r_override;
  assign pressed   = key_is_down(r_state);
  assign key_state = r_state;

endmodule
